// File: rtl/aes_sys_ctrl_q_pkg.sv
// rtl/aes_sys_ctrl_q_pkg.sv - shared types and encodings for the AES sequencing controller
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_START,
        ST_KEY_WAIT,
        ST_PC_START,
        ST_PC_WAIT,
        ST_ERROR
    } state_t;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_BAD = 2'b11;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_TMO    = 2'b01;
    localparam logic [1:0] ERR_KEYLEN = 2'b10;

    function automatic logic is_wait(input state_t s);
        return (s == ST_KEY_WAIT) || (s == ST_PC_WAIT);
    endfunction

endpackage

// File: rtl/aes_sys_ctrl_q_if.sv
// rtl/aes_sys_ctrl_q_if.sv - load strobes, engine handshakes and status of the AES controller
interface aes_sys_ctrl_q_if #(
    parameter int PEND_DEPTH = 4
);
    localparam int PEND_W = $clog2(PEND_DEPTH + 1);

    logic              load_key;
    logic [1:0]        key_len;
    logic              load_data;
    logic              decrypt;
    logic              keylogic_done;
    logic              pcore_done;
    logic              clr_err;
    logic              keylogic_start;
    logic              keylogic_mode;
    logic [1:0]        key_len_o;
    logic              pcore_start;
    logic              pcore_decrypt;
    logic              ready_new_input;
    logic              key_valid;
    logic [PEND_W-1:0] pend_count;
    logic              busy;
    logic              ovf;
    logic [1:0]        err_code;

    modport master (
        output load_key, key_len, load_data, decrypt, keylogic_done, pcore_done, clr_err,
        input  keylogic_start, keylogic_mode, key_len_o, pcore_start, pcore_decrypt,
               ready_new_input, key_valid, pend_count, busy, ovf, err_code
    );

    modport slave (
        input  load_key, key_len, load_data, decrypt, keylogic_done, pcore_done, clr_err,
        output keylogic_start, keylogic_mode, key_len_o, pcore_start, pcore_decrypt,
               ready_new_input, key_valid, pend_count, busy, ovf, err_code
    );

endinterface

// File: rtl/aes_sys_ctrl_q_mode_fifo.sv
// rtl/aes_sys_ctrl_q_mode_fifo.sv - 1-bit FIFO holding the encrypt/decrypt mode of queued blocks
module mode_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic          din,
    output logic          dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_sys_ctrl_q.sv
// rtl/aes_sys_ctrl_q.sv - AES sequencer: key expansion, queued back-to-back P-Core runs, watchdog and error state
module aes_sys_ctrl_q
    import aes_ctrl_pkg::*;
#(
    parameter int PEND_DEPTH  = 4,
    parameter int PEND_W      = $clog2(PEND_DEPTH + 1),
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMO_W       = 16
) (
    input logic             clk,
    input logic             rst_n,
    aes_sys_ctrl_q_if.slave bus
);
    state_t            state;
    state_t            state_n;
    logic [1:0]        key_len_q;
    logic [1:0]        err_q;
    logic              key_valid_q;
    logic              pcore_decrypt_q;
    logic              ovf_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              push;
    logic              pop;
    logic              flush;
    logic              ovf_set;
    logic              fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PEND_W-1:0] pend_cnt;

    assign pop     = (state == ST_PC_START);
    assign push    = bus.load_data && (state != ST_ERROR);
    assign flush   = (state == ST_ERROR) && bus.clr_err;
    assign ovf_set = push && fifo_full && !pop;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    mode_fifo #(
        .DEPTH (PEND_DEPTH),
        .CW    (PEND_W)
    ) u_mode_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.decrypt),
        .dout  (fifo_head),
        .count (pend_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (bus.load_key) begin
                    state_n = (bus.key_len == KL_BAD) ? ST_ERROR : ST_KEY_START;
                end else if (!fifo_empty && key_valid_q) begin
                    state_n = ST_PC_START;
                end
            end
            ST_KEY_START: state_n = ST_KEY_WAIT;
            ST_KEY_WAIT: begin
                // done on the last allowed wait cycle still beats the watchdog
                if (bus.keylogic_done) begin
                    state_n = fifo_empty ? ST_IDLE : ST_PC_START;
                end else if (tmo_hit) begin
                    state_n = ST_ERROR;
                end
            end
            ST_PC_START: state_n = ST_PC_WAIT;
            ST_PC_WAIT: begin
                if (bus.pcore_done) begin
                    state_n = fifo_empty ? ST_IDLE : ST_PC_START;
                end else if (tmo_hit) begin
                    state_n = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (bus.clr_err) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.keylogic_start  = (state == ST_KEY_START);
        bus.keylogic_mode   = (state != ST_KEY_WAIT);
        bus.pcore_start     = (state == ST_PC_START);
        bus.ready_new_input = (state == ST_IDLE);
        bus.busy            = (state == ST_KEY_START) || (state == ST_KEY_WAIT) ||
                              (state == ST_PC_START)  || (state == ST_PC_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_len_q       <= KL_128;
            key_valid_q     <= 1'b0;
            pcore_decrypt_q <= 1'b0;
            ovf_q           <= 1'b0;
            err_q           <= ERR_NONE;
            tmo_cnt         <= '0;
        end else begin
            if (is_wait(state)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if ((state == ST_IDLE) && bus.load_key && (bus.key_len != KL_BAD)) begin
                key_len_q   <= bus.key_len;
                key_valid_q <= 1'b0;
            end
            if ((state == ST_KEY_WAIT) && bus.keylogic_done) begin
                key_valid_q <= 1'b1;
            end
            if (pop) begin
                pcore_decrypt_q <= fifo_head;
            end

            // Error entry from IDLE can only be a bad key length; from a wait state only the watchdog.
            if ((state_n == ST_ERROR) && (state != ST_ERROR)) begin
                err_q <= (state == ST_IDLE) ? ERR_KEYLEN : ERR_TMO;
            end
            if (flush) begin
                key_valid_q <= 1'b0;
                err_q       <= ERR_NONE;
            end

            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.key_len_o     = key_len_q;
    assign bus.key_valid     = key_valid_q;
    assign bus.pcore_decrypt = pcore_decrypt_q;
    assign bus.pend_count    = pend_cnt;
    assign bus.ovf           = ovf_q;
    assign bus.err_code      = err_q;

endmodule

// File: tb/tb_aes_sys_ctrl_q.sv
// tb/tb_aes_sys_ctrl_q.sv - directed and randomized self-checking bench for aes_sys_ctrl_q
module tb_aes_sys_ctrl_q;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int M_IDLE = 0, M_KS = 1, M_KW = 2, M_PCS = 3, M_PCW = 4, M_ERR = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       t_load_key, t_load_data, t_dec, t_clr, t_kl, t_pc;
    logic [1:0] t_key_len;
    logic       rsp_kl = 1'b0, rsp_pc = 1'b0, resp_en;
    int         kl_delay = 5, pc_delay = 4, kl_cnt = 0, pc_cnt = 0;
    int         n_tests = 0, n_fail = 0;

    aes_sys_ctrl_q_if #(.PEND_DEPTH(DEPTH)) bus();

    aes_sys_ctrl_q #(
        .PEND_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .TMO_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.load_key      = t_load_key;
    assign bus.key_len       = t_key_len;
    assign bus.load_data     = t_load_data;
    assign bus.decrypt       = t_dec;
    assign bus.clr_err       = t_clr;
    assign bus.keylogic_done = resp_en ? rsp_kl : t_kl;
    assign bus.pcore_done    = resp_en ? rsp_pc : t_pc;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // engine stand-ins: done pulse a fixed number of cycles after each start (0 = never)
    always @(negedge clk) begin
        rsp_kl = 1'b0;
        rsp_pc = 1'b0;
        if (kl_cnt > 0) begin kl_cnt--; rsp_kl = (kl_cnt == 0); end
        if (pc_cnt > 0) begin pc_cnt--; rsp_pc = (pc_cnt == 0); end
        if (bus.keylogic_start) kl_cnt = kl_delay;
        if (bus.pcore_start)    pc_cnt = pc_delay;
    end

    // reference model: queue of modes plus the controller's rules
    int         m_st = M_IDLE, m_wait = 0;
    bit         mq[$];
    bit         m_kv = 0, m_dec = 0, m_ovf = 0;
    logic [1:0] m_klen = 2'b00, m_err = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; mq.delete(); m_wait = 0;
            m_kv = 0; m_dec = 0; m_ovf = 0; m_klen = 2'b00; m_err = 2'b00;
        end else begin
            int n;
            bit popping, pushing, ovf_evt;
            n       = mq.size();
            popping = (m_st == M_PCS);
            pushing = bus.load_data && (m_st != M_ERR);
            ovf_evt = 0;
            if (m_st == M_ERR && bus.clr_err) mq.delete();
            else begin
                if (popping && n > 0) m_dec = mq.pop_front();
                if (pushing) begin
                    if (n < DEPTH || popping) mq.push_back(bus.decrypt);
                    else ovf_evt = 1;
                end
            end
            if (ovf_evt) m_ovf = 1;
            else if (bus.clr_err) m_ovf = 0;
            case (m_st)
                M_IDLE: begin
                    if (bus.load_key) begin
                        if (bus.key_len == 2'b11) begin m_st = M_ERR; m_err = 2'b10; end
                        else begin m_st = M_KS; m_klen = bus.key_len; m_kv = 0; end
                    end else if (n > 0 && m_kv) m_st = M_PCS;
                end
                M_KS: begin m_st = M_KW; m_wait = 0; end
                M_KW: begin
                    if (bus.keylogic_done) begin m_kv = 1; m_st = (n > 0) ? M_PCS : M_IDLE; end
                    else if (m_wait == TMO - 1) begin m_st = M_ERR; m_err = 2'b01; end
                    else m_wait++;
                end
                M_PCS: begin m_st = M_PCW; m_wait = 0; end
                M_PCW: begin
                    if (bus.pcore_done) m_st = (n > 0) ? M_PCS : M_IDLE;
                    else if (m_wait == TMO - 1) begin m_st = M_ERR; m_err = 2'b01; end
                    else m_wait++;
                end
                default: begin
                    if (bus.clr_err) begin m_st = M_IDLE; m_kv = 0; m_err = 2'b00; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("ready", bus.ready_new_input, m_st == M_IDLE);
        chk("busy", bus.busy, m_st inside {M_KS, M_KW, M_PCS, M_PCW});
        chk("kl_start", bus.keylogic_start, m_st == M_KS);
        chk("kl_mode", bus.keylogic_mode, m_st != M_KW);
        chk("pc_start", bus.pcore_start, m_st == M_PCS);
        chk("key_len_o", bus.key_len_o, m_klen);
        chk("key_valid", bus.key_valid, m_kv);
        chk("pc_decrypt", bus.pcore_decrypt, m_dec);
        chk("pend_count", bus.pend_count, mq.size());
        chk("ovf", bus.ovf, m_ovf);
        chk("err_code", bus.err_code, m_err);
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && !(bus.ready_new_input && bus.pend_count == 0); i++) tick();
        chk("idle_reached", bus.ready_new_input && bus.pend_count == 0, 1);
    endtask

    task automatic wait_pcs(input int budget);
        for (int i = 0; i < budget && !bus.pcore_start; i++) tick();
        chk("pcs_seen", bus.pcore_start, 1);
    endtask

    int  starts, gap, ks, km;
    bit  cap;
    bit  decs[$];
    bit  pat[0:2];

    initial begin
        t_load_key = 0; t_key_len = 0; t_load_data = 0; t_dec = 0; t_clr = 0;
        t_kl = 0; t_pc = 0; resp_en = 1;
        pat[0] = 1; pat[1] = 0; pat[2] = 1;
        repeat (3) tick();
        chk("rst_ready", bus.ready_new_input, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mode", bus.keylogic_mode, 1);
        chk("rst_err", bus.err_code, 0);
        rst_n = 1;

        // data before any key: queued, nothing starts
        t_load_data = 1; t_dec = 1; tick(); t_load_data = 0;
        starts = 0;
        repeat (6) begin if (bus.pcore_start) starts++; tick(); end
        chk("early_pend", bus.pend_count, 1);
        chk("early_nostart", starts, 0);
        kl_delay = 3;
        t_load_key = 1; t_key_len = 2'b00; tick(); t_load_key = 0;
        for (int i = 0; i < 40 && !bus.keylogic_done; i++) tick();
        chk("kl_done_seen", bus.keylogic_done, 1);
        tick();
        chk("pcs_after_done", bus.pcore_start, 1);
        wait_idle(60);

        // 256-bit key, done 5 cycles after start
        kl_delay = 5;
        t_load_key = 1; t_key_len = 2'b10; tick(); t_load_key = 0;
        ks = 0; km = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.keylogic_start) ks++;
            if (!bus.keylogic_mode) km++;
            if (bus.ready_new_input) break;
            tick();
        end
        chk("kl_start_width", ks, 1);
        chk("kl_wait_cycles", km, 5);
        chk("kl_len_256", bus.key_len_o, 2);
        chk("kl_valid", bus.key_valid, 1);

        // three blocks back to back
        pc_delay = 4;
        starts = 0; gap = 0; cap = 0; decs.delete();
        for (int i = 0; i < 100; i++) begin
            t_load_data = (i < 3);
            if (i < 3) t_dec = pat[i];
            if (cap) begin decs.push_back(bus.pcore_decrypt); cap = 0; end
            if (bus.pcore_start) begin starts++; cap = 1; end
            if (starts > 0 && starts < 3 && bus.ready_new_input) gap++;
            if (starts == 3 && !cap && bus.ready_new_input) break;
            tick();
        end
        t_load_data = 0;
        chk("b2b_starts", starts, 3);
        chk("b2b_no_idle", gap, 0);
        chk("b2b_ndec", decs.size(), 3);
        for (int k = 0; k < 3 && k < decs.size(); k++) chk("b2b_dec", decs[k], pat[k]);
        chk("b2b_pend", bus.pend_count, 0);
        chk("model_idle", m_st, M_IDLE);

        // overflow while P-Core is busy
        pc_delay = 10;
        t_load_data = 1; t_dec = 0; tick(); t_load_data = 0;
        wait_pcs(20);
        tick();
        for (int k = 0; k < 5; k++) begin t_load_data = 1; t_dec = k[0]; tick(); end
        t_load_data = 0;
        chk("ovf_pend", bus.pend_count, 4);
        chk("ovf_set", bus.ovf, 1);
        chk("model_full", mq.size(), 4);
        wait_pcs(20);
        t_load_data = 1; tick(); t_load_data = 0;
        chk("ovf_pushpop_pend", bus.pend_count, 4);
        chk("ovf_pushpop_ovf", bus.ovf, 1);
        t_clr = 1; tick(); t_clr = 0;
        chk("clr_ovf_only", bus.ovf, 0);
        chk("clr_still_busy", bus.busy, 1);
        wait_idle(200);

        // watchdog timeout in PC_WAIT
        pc_delay = 0;
        t_load_data = 1; tick(); t_load_data = 0;
        wait_pcs(20);
        tick();
        t_load_data = 1; t_dec = 1; tick(); t_load_data = 0;
        repeat (TMO - 2) tick();
        chk("tmo_last_wait", bus.busy, 1);
        chk("tmo_no_err_yet", bus.err_code, 0);
        tick();
        chk("tmo_err", bus.err_code, 1);
        chk("tmo_not_ready", bus.ready_new_input, 0);
        chk("tmo_pend", bus.pend_count, 1);
        t_load_data = 1; tick(); t_load_data = 0;
        chk("err_drop_pend", bus.pend_count, 1);
        chk("err_drop_ovf", bus.ovf, 0);
        t_clr = 1; tick(); t_clr = 0;
        chk("clr_ready", bus.ready_new_input, 1);
        chk("clr_pend", bus.pend_count, 0);
        chk("clr_kv", bus.key_valid, 0);
        chk("clr_err", bus.err_code, 0);

        // illegal key length
        t_load_key = 1; t_key_len = 2'b11; tick(); t_load_key = 0;
        chk("badkey_err", bus.err_code, 2);
        chk("badkey_state", bus.ready_new_input || bus.busy, 0);
        chk("badkey_len_kept", bus.key_len_o, 2);
        t_clr = 1; tick(); t_clr = 0;
        chk("badkey_clr", bus.err_code, 0);

        // asynchronous reset in PC_WAIT
        kl_delay = 2;
        t_load_key = 1; t_key_len = 2'b01; tick(); t_load_key = 0;
        wait_idle(40);
        t_load_data = 1; t_dec = 1; tick(); t_load_data = 0;
        wait_pcs(20);
        tick(); tick();
        chk("pre_rst_dec", bus.pcore_decrypt, 1);
        @(posedge clk); #2; rst_n = 0; #1;
        chk("arst_ready", bus.ready_new_input, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_kv", bus.key_valid, 0);
        chk("arst_len", bus.key_len_o, 0);
        chk("arst_dec", bus.pcore_decrypt, 0);
        chk("arst_pend", bus.pend_count, 0);
        tick();
        rst_n = 1;

        // randomized traffic checked cycle-by-cycle against the model
        resp_en = 0;
        for (int i = 0; i < 3000; i++) begin
            t_load_key  = ($urandom_range(0, 11) == 0);
            t_key_len   = 2'($urandom_range(0, 3));
            t_load_data = ($urandom_range(0, 2) == 0);
            t_dec       = 1'($urandom_range(0, 1));
            t_kl        = ($urandom_range(0, 5) == 0);
            t_pc        = ($urandom_range(0, 5) == 0);
            t_clr       = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sys_ctrl_q.md
Name: aes_sys_ctrl_q

Overview:
Top-level sequencing controller for the AES core. It is the parametrised successor of the single-shot system controller and adds:
- selectable key length (128/192/256) and per-block encrypt/decrypt
- a queue of pending data-load requests, with back-to-back P-Core runs
- key-valid gating, a done-watchdog and an error state with software clear.
It sits between the bus interface (load strobes) and the KeyLogic / P-Core engines (start/done).

Parameters:
PEND_DEPTH, 4, max queued data blocks awaiting P-Core (≥1)
PEND_W, $clog2(PEND_DEPTH+1), width of pend_count (derived; do not override)
TIMEOUT_CYC, 1000, max cycles in a wait state before a timeout error (≥2)
TMO_W, 16, watchdog counter width; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_key  in  1  key-load strobe; accepted only in IDLE
key_len  in  2  00=128, 01=192, 10=256, 11=illegal; sampled with an accepted load_key
load_data  in  1  data-load strobe; pushes one entry into the pending queue
decrypt  in  1  mode of the block pushed with load_data (1=decrypt)
keylogic_done  in  1  key expansion complete (level or pulse)
pcore_done  in  1  P-Core block complete (level or pulse)
clr_err  in  1  leave ERROR, flush queue, clear ovf
keylogic_start  out  1  one-cycle start pulse to KeyLogic
keylogic_mode  out  1  0 while in KEY_WAIT, else 1
key_len_o  out  2  latched key length driven to KeyLogic/P-Core
pcore_start  out  1  one-cycle start pulse to P-Core
pcore_decrypt  out  1  mode of the block currently in P-Core
ready_new_input  out  1  1 iff state==IDLE
key_valid  out  1  expanded key present and usable
pend_count  out  PEND_W  number of queued blocks
busy  out  1  state in {KEY_START, KEY_WAIT, PC_START, PC_WAIT}
ovf  out  1  sticky: a load_data was dropped because the queue was full
err_code  out  2  00 none, 01 watchdog timeout, 10 illegal key_len; held until clr_err

Behaviour:
- Reset values:
  - state=IDLE; key_valid=0; pend_count=0; queue empty.
  - key_len_o=00; pcore_decrypt=0; ovf=0; err_code=00.
  - Outputs decode from state, so keylogic_start=0, pcore_start=0, keylogic_mode=1, ready_new_input=1, busy=0.
- States: IDLE, KEY_START, KEY_WAIT, PC_START, PC_WAIT, ERROR. Start, mode, ready and busy outputs are pure decodes of the state register.
- IDLE, in priority order:
  - load_key with key_len≠11 → KEY_START; latch key_len_o; clear key_valid.
  - load_key with key_len==11 → ERROR; err_code=10.
  - else pend_count>0 and key_valid → PC_START.
  - else stay in IDLE.
- KEY_START: one cycle, then → KEY_WAIT.
- KEY_WAIT, on keylogic_done:
  - set key_valid next cycle;
  - → PC_START if pend_count>0, else → IDLE.
- PC_START: one cycle.
  - Pop the queue head into pcore_decrypt.
  - Decrement pend_count, unless a push happens in the same cycle.
  - → PC_WAIT.
- PC_WAIT, on pcore_done: → PC_START if pend_count>0 (back-to-back, no IDLE cycle), else → IDLE.
- load_key outside IDLE is silently ignored.
- Watchdog:
  - Counter clears on entry to KEY_WAIT/PC_WAIT and increments each cycle there.
  - If done is not seen by wait cycle TIMEOUT_CYC (counter==TIMEOUT_CYC-1 without done) → ERROR, err_code=01.
  - done on that same cycle wins.
- ERROR:
  - All starts are 0 and ready_new_input=0.
  - load_data is dropped and does not set ovf.
  - Stays in ERROR until clr_err. Then → IDLE next cycle, flushing the queue (pend_count=0), clearing key_valid, ovf and err_code.
  - clr_err outside ERROR clears only ovf.
- Queue (push side):
  - load_data pushes the decrypt bit in any non-ERROR state.
  - Push and pop in the same cycle with count==PEND_DEPTH: both accepted, count unchanged.
  - Push when count==PEND_DEPTH with no pop: dropped, ovf=1.
- Reset asserted mid-operation aborts immediately to the reset values. Engines must be reset by the same rst_n.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the state enum;
  - key_len encodings: KL_128, KL_192, KL_256, KL_BAD;
  - err_code constants: ERR_NONE, ERR_TMO, ERR_KEYLEN.
- Sub-module mode_fifo: synchronous 1-bit FIFO, depth PEND_DEPTH, with push/pop/flush and count output. The controller instantiates it for the decrypt bits and pend_count.

Test Plan:
- Reset, load_key key_len=10, keylogic_done 5 cycles after keylogic_start → keylogic_start high exactly 1 cycle; keylogic_mode=0 only in KEY_WAIT; key_len_o=10; key_valid=1; back in IDLE.
- With key_valid, 3 load_data pulses (decrypt 1,0,1), pcore_done 4 cycles after each start → 3 pcore_start pulses with no IDLE between them; pcore_decrypt sequence 1,0,1; pend_count 3→0; final state IDLE.
- load_data before any key → pend_count=1, no pcore_start; then load_key and keylogic_done → PC_START the cycle after done.
- PEND_DEPTH=4: 5 pushes while in PC_WAIT → pend_count=4, ovf=1; then push coincident with PC_START at count=4 → count stays 4, ovf unchanged.
- pcore_done withheld for TIMEOUT_CYC cycles → ERROR, err_code=01, ready_new_input=0; load_data ignored. clr_err → IDLE, pend_count=0, key_valid=0, err_code=00.
- load_key with key_len=11 → ERROR, err_code=10. Also rst_n low during PC_WAIT → all outputs at reset values asynchronously.
